// File: rtl/instr_port_arbiter.sv
// Two-port arbiter in front of a single-port combinational instruction ROM.
// Fetch has priority; debug is guaranteed a grant after MAX_WAIT lost cycles.
module instr_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_instr
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              dbg_err_q, dbg_err_d;

    logic              dbg_wins;
    logic              any_gnt;
    logic              in_range;
    logic [DATA_W-1:0] rom_data;

    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    always_comb begin
        dbg_wins = dbg_req & (~if_req | (wait_cnt_q == MAX_WAIT_C));
        dbg_gnt  = dbg_wins;
        if_gnt   = if_req & ~dbg_wins;
        if_stall = if_req & ~if_gnt;
        any_gnt  = if_gnt | dbg_gnt;

        rom_addr = '0;
        if (dbg_gnt)
            rom_addr = dbg_addr;
        else if (if_gnt)
            rom_addr = if_addr;

        in_range = (rom_addr[ADDR_W-1:DEPTH_LOG2+2] == '0);
        rom_ce   = any_gnt & in_range;
        // Out-of-range reads return zero (a NOP for the pipeline).
        rom_data = rom_ce ? rom_instr : '0;
    end

    always_comb begin
        wait_cnt_d = '0;
        if (dbg_req && !dbg_gnt)
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;

        if_rvalid_d  = if_gnt;
        if_rdata_d   = if_gnt ? rom_data : if_rdata_q;
        dbg_rvalid_d = dbg_gnt;
        dbg_rdata_d  = dbg_gnt ? rom_data : dbg_rdata_q;
        dbg_err_d    = dbg_gnt & ~in_range;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q   <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
            dbg_err_q    <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_err_q    <= dbg_err_d;
        end
    end

    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_err    = dbg_err_q;

endmodule

// File: doc/instr_port_arbiter.md
Name: instr_port_arbiter

Overview:
Shares the single-port, combinational-read instruction ROM between two requesters: the pipeline IF stage (port 0) and a debug/monitor reader (port 1). The block sits between both requesters and the ROM's ce/addr/instr port. It arbitrates each cycle, with fetch given priority and a bounded-wait guarantee for debug. It registers the returned word, range-checks addresses, and drives a fetch stall for the pipeline control logic.

Parameters:
ADDR_W, 32, requester and ROM address width
DATA_W, 32, instruction word width
DEPTH_LOG2, 8, log2 of ROM depth in words (256 words; word index = addr[DEPTH_LOG2+1:2])
MAX_WAIT, 4, max consecutive cycles a pending debug request may lose to fetch (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch granted this cycle (combinational)
if_stall  out  1  if_req & ~if_gnt (combinational)
if_rvalid  out  1  one-cycle pulse, fetch data valid
if_rdata  out  DATA_W  fetch data (registered)
dbg_req  in  1  debug request; held with dbg_addr until dbg_gnt
dbg_addr  in  ADDR_W  debug byte address
dbg_gnt  out  1  debug granted this cycle (combinational)
dbg_rvalid  out  1  one-cycle pulse, debug data valid
dbg_rdata  out  DATA_W  debug data (registered)
dbg_err  out  1  with dbg_rvalid: address was out of range
rom_ce  out  1  ROM chip enable
rom_addr  out  ADDR_W  ROM byte address
rom_instr  in  DATA_W  ROM read data (combinational from rom_ce/rom_addr)

Behaviour:
- Reset (rst=1 at posedge): if_rvalid, dbg_rvalid and dbg_err clear to 0; if_rdata and dbg_rdata clear to 0; wait_cnt clears to 0. Any response due the following cycle is dropped. Combinational grants still evaluate from their inputs during reset.
- Arbitration is combinational, at most one grant per cycle:
  - Only if_req asserted: fetch wins.
  - Only dbg_req asserted: debug wins.
  - Both asserted: fetch wins unless wait_cnt == MAX_WAIT, in which case debug wins.
- wait_cnt (4-bit) update at posedge:
  - Increments when dbg_req=1 and dbg_gnt=0.
  - Clears when dbg_gnt=1 or dbg_req=0.
  - Saturates at MAX_WAIT.
- rom_addr: the winner's address when a grant is given, else 0.
- rom_ce: 1 only when a grant is given and the winner's address is in range. In range means addr[ADDR_W-1:DEPTH_LOG2+2] == 0.
- addr[1:0] is ignored; no alignment error is raised.
- Latency: a grant in cycle N produces rvalid=1 with data in cycle N+1, captured from rom_instr at the posedge ending cycle N. rvalid pulses exactly one cycle per grant.
- Back-to-back grants to the same port give rvalid on consecutive cycles, and rdata updates every cycle.
- rdata holds its last value while rvalid=0.
- Out-of-range grant:
  - rom_ce=0; the captured data is 32'h0.
  - For fetch: if_rdata = 32'h0 (NOP), if_rvalid=1, no error flag.
  - For debug: dbg_rdata = 0, dbg_rvalid=1, dbg_err=1 for that one cycle.
- Requesters must hold req and addr stable until granted. A req dropped before grant is simply not served, and wait_cnt clears.
- No grant and no rvalid is ever produced for a port whose req=0.

Test Plan:
- ROM model preloaded word0=0x3401001D, word1=0x00421026. Assert if_req, if_addr=0x0 then 0x4 on consecutive cycles -> if_gnt=1 both cycles; if_rvalid on the next two cycles with if_rdata 0x3401001D then 0x00421026; rom_ce=1.
- Assert dbg_req alone, dbg_addr=0x4 -> dbg_gnt same cycle; next cycle dbg_rvalid=1, dbg_rdata=0x00421026, dbg_err=0; if_stall=0 throughout.
- if_req held continuously; dbg_req raised with MAX_WAIT=4 -> fetch granted 4 cycles with if_stall=0; 5th cycle dbg_gnt=1, if_gnt=0, if_stall=1; wait_cnt returns to 0 and fetch resumes the next cycle.
- dbg_addr=0x400 (word 256, out of range) -> rom_ce=0 in the grant cycle; next cycle dbg_rvalid=1, dbg_err=1, dbg_rdata=0. The same test with if_addr=0x400 gives if_rvalid=1, if_rdata=0, no error.
- Grant fetch in cycle N; assert rst in cycle N -> if_rvalid=0 in cycle N+1, if_rdata=0, wait_cnt=0.
- dbg_req held 3 cycles under fetch contention, then dropped for 1 cycle, then re-raised -> wait_cnt restarts at 0 and debug waits a full MAX_WAIT cycles again before being granted.
